// File: rtl/mii_pkg.sv
// mii_pkg: shared state type and byte constants for the MII receive front end
package mii_pkg;
   typedef enum logic [1:0] {IDLE, PREAMBLE, FRAME} state_t;
   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE      = 8'hD5;
endpackage

// File: rtl/mii_if.sv
// mii_if: PHY receive pins plus assembled-byte outputs
//  mii_clk/mii_en/mii_d : PHY side (mii_d[0] = nibble LSB)
//  d/rdy/error          : byte stream towards the frame parser
interface mii_if;
   logic       mii_clk;
   logic       mii_en;
   logic [0:3] mii_d;
   logic [7:0] d;
   logic       rdy;
   logic       error;
   modport master (output mii_clk, mii_en, mii_d, input d, rdy, error);
   modport slave  (input mii_clk, mii_en, mii_d, output d, rdy, error);
endinterface

// File: rtl/mii_sync.sv
// mii_sync: synchronises the MII pins into clk and detects mii_clk rising edges
//  clk, rst_n          : system clock, async active-low reset
//  mii_clk_i/en_i/d_i  : raw PHY pins
//  stb_o               : one-clk strobe on a detected mii_clk rising edge
//  en_o, nib_o         : synchronised RX_DV and nibble (nib_o[0] = mii_d[0])
module mii_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       mii_clk_i,
   input  logic       mii_en_i,
   input  logic [0:3] mii_d_i,
   output logic       stb_o,
   output logic       en_o,
   output logic [3:0] nib_o
);
   // all pins share one pipeline so clk, enable and data stay aligned
   logic [5:0] pipe_q [SYNC_STAGES];
   logic       prev_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) pipe_q[i] <= '0;
         prev_q <= 1'b0;
      end else begin
         pipe_q[0] <= {mii_clk_i, mii_en_i, mii_d_i[3], mii_d_i[2], mii_d_i[1], mii_d_i[0]};
         for (int i = 1; i < SYNC_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
         prev_q <= pipe_q[SYNC_STAGES-1][5];
      end
   end
   assign stb_o = pipe_q[SYNC_STAGES-1][5] & ~prev_q;
   assign en_o  = pipe_q[SYNC_STAGES-1][4];
   assign nib_o = pipe_q[SYNC_STAGES-1][3:0];
endmodule

// File: rtl/mii_core.sv
// mii_core: MII receive front end pairing nibbles into bytes with preamble/SFD framing checks
//  clk, rst_n : system clock (>= 2x mii_clk), async active-low reset
//  bus        : mii_if slave; PHY pins in, d/rdy/error out
module mii_core
   import mii_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int MAX_PRE     = 15
) (
   input  logic clk,
   input  logic rst_n,
   mii_if.slave bus
);
   localparam int            CW    = $clog2(MAX_PRE + 1);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_PRE);
   logic          stb, en;
   logic [3:0]    nib;
   logic [7:0]    rx_byte;
   state_t        state_q, state_d;
   logic          phase_q, phase_d;
   logic [3:0]    lo_q, lo_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    d_q, d_d;
   logic          rdy_q, rdy_d;
   logic          err_q, err_d;
   logic          armed_q, armed_d;
   mii_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .mii_clk_i (bus.mii_clk),
      .mii_en_i  (bus.mii_en),
      .mii_d_i   (bus.mii_d),
      .stb_o     (stb),
      .en_o      (en),
      .nib_o     (nib)
   );
   assign rx_byte = {nib, lo_q};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         phase_q <= 1'b0;
         lo_q    <= '0;
         cnt_q   <= '0;
         d_q     <= '0;
         rdy_q   <= 1'b0;
         err_q   <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         lo_q    <= lo_d;
         cnt_q   <= cnt_d;
         d_q     <= d_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
         armed_q <= armed_d;
      end
   end
   // armed_q blocks a frame already in progress at reset release until RX_DV is seen low
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      d_d     = d_q;
      rdy_d   = 1'b0;
      err_d   = err_q;
      armed_d = armed_q | (stb & ~en);
      if (stb) begin
         if (state_q == IDLE) begin
            if (en && armed_q) begin
               state_d = PREAMBLE;
               err_d   = 1'b0;
               phase_d = 1'b1;
               lo_d    = nib;
               cnt_d   = '0;
            end
         end else if (!en) begin
            state_d = IDLE;
            phase_d = 1'b0;
            if (phase_q || state_q == PREAMBLE) err_d = 1'b1;
         end else if (!phase_q) begin
            lo_d    = nib;
            phase_d = 1'b1;
         end else begin
            phase_d = 1'b0;
            d_d     = rx_byte;
            rdy_d   = 1'b1;
            if (state_q == PREAMBLE) begin
               if (rx_byte == SFD_BYTE) state_d = FRAME;
               else if (rx_byte != PREAMBLE_BYTE || cnt_q == MAX_C) err_d = 1'b1;
               else cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end
   assign bus.d     = d_q;
   assign bus.rdy   = rdy_q;
   assign bus.error = err_q;
endmodule

// File: tb/tb_mii_core.sv
// tb_mii_core: self-checking bench for mii_core with a byte scoreboard
module tb_mii_core;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   mii_if bus ();
   mii_core dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #10 clk = ~clk;
   typedef struct {
      logic [7:0] b;
      logic       err;
   } vec_t;
   vec_t       tv [14];
   logic [7:0] sb [$];
   logic [7:0] fr [$];
   int pass_cnt = 0;
   int total_cnt = 0;
   int rdy_cnt = 0;
   int n0;
   logic prev_rdy = 1'b0;
   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask
   always @(negedge clk) begin
      if (bus.rdy) begin
         rdy_cnt++;
         check("rdy_single", {7'd0, prev_rdy}, 8'd0);
         if (sb.size() == 0) begin
            total_cnt++;
            $display("FAIL rdy_unexpected: got rdy with d=%h expected no rdy", bus.d);
         end else check("rdy_d", bus.d, sb.pop_front());
      end
      prev_rdy = bus.rdy;
   end
   task automatic send_nib(input logic [3:0] n, input logic en);
      bus.mii_clk = 1'b0;
      #5;
      bus.mii_en = en;
      bus.mii_d = {n[0], n[1], n[2], n[3]};
      @(negedge clk);
      bus.mii_clk = 1'b1;
      @(negedge clk);
   endtask
   task automatic send_byte(input logic [7:0] b, input logic exp);
      send_nib(b[3:0], 1'b1);
      send_nib(b[7:4], 1'b1);
      if (exp) sb.push_back(b);
   endtask
   task automatic idle(input int n);
      repeat (n) send_nib(4'($urandom), 1'b0);
   endtask
   task automatic settle();
      repeat (3) @(negedge clk);
   endtask
   task automatic preamble(input int n);
      repeat (n) send_byte(8'h55, 1'b1);
      send_byte(8'hD5, 1'b1);
   endtask
   task automatic clean_frame();
      preamble(7);
      foreach (fr[i]) send_byte(fr[i], 1'b1);
      send_nib(4'h0, 1'b0);
      settle();
   endtask
   initial begin
      bus.mii_clk = 1'b0;
      bus.mii_en  = 1'b0;
      bus.mii_d   = '0;
      repeat (3) @(negedge clk);
      check("rst_d", bus.d, 8'h00);
      check("rst_rdy", {7'd0, bus.rdy}, 8'd0);
      check("rst_err", {7'd0, bus.error}, 8'd0);
      rst_n = 1'b1;
      idle(6);
      check("idle_d", bus.d, 8'h00);
      check("idle_err", {7'd0, bus.error}, 8'd0);
      for (int i = 0; i < 7; i++) tv[i] = '{8'h55, 1'b0};
      tv[7]  = '{8'hD5, 1'b0};
      tv[8]  = '{8'h54, 1'b0};
      tv[9]  = '{8'hFF, 1'b0};
      tv[10] = '{8'h01, 1'b0};
      tv[11] = '{8'h21, 1'b0};
      tv[12] = '{8'h23, 1'b0};
      tv[13] = '{8'h24, 1'b0};
      for (int i = 0; i < 14; i++) begin
         send_byte(tv[i].b, 1'b1);
         settle();
         check($sformatf("vec%0d_err", i), {7'd0, bus.error}, {7'd0, tv[i].err});
      end
      send_nib(4'h0, 1'b0);
      settle();
      check("vec_end_err", {7'd0, bus.error}, 8'd0);
      check("vec_sb_empty", 8'(sb.size()), 8'd0);
      idle(3);
      fr = '{8'h54, 8'hFF, 8'h01, 8'h21, 8'h23, 8'h24, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h12, 8'h34};
      for (int i = 0; i < 42; i++) fr.push_back(8'(i * 7 + 3));
      fr.push_back(8'h64);
      fr.push_back(8'h90);
      fr.push_back(8'h02);
      fr.push_back(8'hFB);
      n0 = rdy_cnt;
      clean_frame();
      check("frame_rdy_cnt", 8'(rdy_cnt - n0), 8'd68);
      check("frame_err", {7'd0, bus.error}, 8'd0);
      check("frame_sb_empty", 8'(sb.size()), 8'd0);
      idle(3);
      preamble(7);
      send_byte(8'hAB, 1'b1);
      send_nib(4'hC, 1'b1);
      send_nib(4'h0, 1'b0);
      settle();
      check("odd_err", {7'd0, bus.error}, 8'd1);
      idle(4);
      check("odd_err_held", {7'd0, bus.error}, 8'd1);
      send_byte(8'h55, 1'b1);
      settle();
      check("start_clears_err", {7'd0, bus.error}, 8'd0);
      send_byte(8'h57, 1'b1);
      settle();
      check("bad_pre_err", {7'd0, bus.error}, 8'd1);
      send_byte(8'h55, 1'b1);
      send_byte(8'hD5, 1'b1);
      send_byte(8'h3C, 1'b1);
      send_nib(4'h0, 1'b0);
      settle();
      check("bad_pre_sticky", {7'd0, bus.error}, 8'd1);
      idle(3);
      repeat (15) send_byte(8'h55, 1'b1);
      settle();
      check("pre15_err", {7'd0, bus.error}, 8'd0);
      send_byte(8'h55, 1'b1);
      settle();
      check("pre16_err", {7'd0, bus.error}, 8'd1);
      send_byte(8'hD5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_nib(4'h0, 1'b0);
      settle();
      check("pre16_sticky", {7'd0, bus.error}, 8'd1);
      idle(3);
      repeat (3) send_byte(8'h55, 1'b1);
      settle();
      check("nosfd_mid_err", {7'd0, bus.error}, 8'd0);
      send_nib(4'h0, 1'b0);
      settle();
      check("nosfd_err", {7'd0, bus.error}, 8'd1);
      idle(3);
      preamble(7);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_nib(4'h3, 1'b1);
      rst_n = 1'b0;
      #1;
      sb.delete();
      check("midrst_d", bus.d, 8'h00);
      check("midrst_rdy", {7'd0, bus.rdy}, 8'd0);
      check("midrst_err", {7'd0, bus.error}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) send_byte(8'h99, 1'b0);
      send_nib(4'h0, 1'b0);
      settle();
      check("after_rst_err", {7'd0, bus.error}, 8'd0);
      idle(3);
      n0 = rdy_cnt;
      clean_frame();
      check("rerun_rdy_cnt", 8'(rdy_cnt - n0), 8'd68);
      check("rerun_err", {7'd0, bus.error}, 8'd0);
      check("rerun_sb_empty", 8'(sb.size()), 8'd0);
      idle(2);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
